// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction decode between fetch and execute.
// Drives rf read addresses, registers the decoded control fields and
// presents rf operands alongside them with a valid/ready handshake.
// Optional feature macro: DECODE_WB_BYPASS_EN (same-edge writeback bypass).
module decode_stage #(
  parameter int unsigned DATA_WIDTH             = 32,
  parameter int unsigned REGISTER_ADDRESS_WIDTH = 5
) (
  input  logic                              clk,
  input  logic                              s_reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_instr,
  input  logic [DATA_WIDTH-1:0]             in_pc,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] rf_address1,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] rf_address2,
  input  logic [DATA_WIDTH-1:0]             rf_read_data_1,
  input  logic [DATA_WIDTH-1:0]             rf_read_data_2,
  input  logic                              wb_we,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] wb_address,
  input  logic [DATA_WIDTH-1:0]             wb_data,
  input  logic                              flush,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_pc,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] out_rd,
  output logic [2:0]                        out_funct3,
  output logic                              out_funct7_b5,
  output logic [3:0]                        out_opclass,
  output logic [DATA_WIDTH-1:0]             out_imm,
  output logic                              out_reg_write,
  output logic                              out_illegal,
  output logic [DATA_WIDTH-1:0]             out_rs1_data,
  output logic [DATA_WIDTH-1:0]             out_rs2_data
);

  localparam int unsigned OPCODE_WIDTH  = 7;
  localparam int unsigned FUNCT3_WIDTH  = 3;
  localparam int unsigned OPCLASS_WIDTH = 4;

  localparam logic [OPCODE_WIDTH-1:0] OPC_LUI      = 7'b0110111;
  localparam logic [OPCODE_WIDTH-1:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [OPCODE_WIDTH-1:0] OPC_JAL      = 7'b1101111;
  localparam logic [OPCODE_WIDTH-1:0] OPC_JALR     = 7'b1100111;
  localparam logic [OPCODE_WIDTH-1:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_LOAD     = 7'b0000011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_STORE    = 7'b0100011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_OP       = 7'b0110011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [OPCODE_WIDTH-1:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [OPCLASS_WIDTH-1:0] {
    CLS_LUI      = 4'd0,
    CLS_AUIPC    = 4'd1,
    CLS_JAL      = 4'd2,
    CLS_JALR     = 4'd3,
    CLS_BRANCH   = 4'd4,
    CLS_LOAD     = 4'd5,
    CLS_STORE    = 4'd6,
    CLS_OP_IMM   = 4'd7,
    CLS_OP       = 4'd8,
    CLS_MISC_MEM = 4'd9,
    CLS_SYSTEM   = 4'd10,
    CLS_ILLEGAL  = 4'd15
  } opclass_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]             pc;
    logic [REGISTER_ADDRESS_WIDTH-1:0] rd;
    logic [FUNCT3_WIDTH-1:0]           funct3;
    logic                              funct7_b5;
    opclass_e                          opclass;
    logic [DATA_WIDTH-1:0]             imm;
    logic                              reg_write;
    logic                              illegal;
  } decode_t;

  logic                              fire_c;
  logic                              out_valid_q;
  decode_t                           dec_c;
  decode_t                           dec_q;
  logic                              writes_rd_c;
  logic [REGISTER_ADDRESS_WIDTH-1:0] rs1_c;
  logic [REGISTER_ADDRESS_WIDTH-1:0] rs2_c;
  logic [REGISTER_ADDRESS_WIDTH-1:0] held_rs1_q;
  logic [REGISTER_ADDRESS_WIDTH-1:0] held_rs2_q;
  logic [DATA_WIDTH-1:0]             imm_i_c;
  logic [DATA_WIDTH-1:0]             imm_s_c;
  logic [DATA_WIDTH-1:0]             imm_b_c;
  logic [DATA_WIDTH-1:0]             imm_u_c;
  logic [DATA_WIDTH-1:0]             imm_j_c;

  // Handshake: flush blocks acceptance; a stalled output register blocks it too.
  assign in_ready = ~flush & (~out_valid_q | out_ready);
  assign fire_c   = in_valid & in_ready;

  // Source indices of the incoming instruction.
  assign rs1_c = REGISTER_ADDRESS_WIDTH'(in_instr[19:15]);
  assign rs2_c = REGISTER_ADDRESS_WIDTH'(in_instr[24:20]);

  // rf reads are registered and re-read every cycle, so during a stall the
  // held indices keep the operands of the waiting instruction current.
  assign rf_address1 = fire_c ? rs1_c : held_rs1_q;
  assign rf_address2 = fire_c ? rs2_c : held_rs2_q;

  // Immediate formats; everything except U is sign-extended from bit 31.
  assign imm_i_c = {{(DATA_WIDTH-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s_c = {{(DATA_WIDTH-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b_c = {{(DATA_WIDTH-13){in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u_c = DATA_WIDTH'({in_instr[31:12], 12'b0});
  assign imm_j_c = {{(DATA_WIDTH-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};

  // Opcode decode into class, immediate and rd-write qualifier.
  always_comb begin
    dec_c           = '0;
    writes_rd_c     = 1'b0;
    dec_c.pc        = in_pc;
    dec_c.rd        = REGISTER_ADDRESS_WIDTH'(in_instr[11:7]);
    dec_c.funct3    = in_instr[14:12];
    dec_c.funct7_b5 = in_instr[30];
    dec_c.opclass   = CLS_ILLEGAL;
    unique case (in_instr[OPCODE_WIDTH-1:0])
      OPC_LUI: begin
        dec_c.opclass = CLS_LUI;
        dec_c.imm     = imm_u_c;
        writes_rd_c   = 1'b1;
      end
      OPC_AUIPC: begin
        dec_c.opclass = CLS_AUIPC;
        dec_c.imm     = imm_u_c;
        writes_rd_c   = 1'b1;
      end
      OPC_JAL: begin
        dec_c.opclass = CLS_JAL;
        dec_c.imm     = imm_j_c;
        writes_rd_c   = 1'b1;
      end
      OPC_JALR: begin
        dec_c.opclass = CLS_JALR;
        dec_c.imm     = imm_i_c;
        writes_rd_c   = 1'b1;
      end
      OPC_BRANCH: begin
        dec_c.opclass = CLS_BRANCH;
        dec_c.imm     = imm_b_c;
      end
      OPC_LOAD: begin
        dec_c.opclass = CLS_LOAD;
        dec_c.imm     = imm_i_c;
        writes_rd_c   = 1'b1;
      end
      OPC_STORE: begin
        dec_c.opclass = CLS_STORE;
        dec_c.imm     = imm_s_c;
      end
      OPC_OP_IMM: begin
        dec_c.opclass = CLS_OP_IMM;
        dec_c.imm     = imm_i_c;
        writes_rd_c   = 1'b1;
      end
      OPC_OP: begin
        dec_c.opclass = CLS_OP;
        writes_rd_c   = 1'b1;
      end
      OPC_MISC_MEM: begin
        dec_c.opclass = CLS_MISC_MEM;
        dec_c.imm     = imm_i_c;
      end
      OPC_SYSTEM: begin
        dec_c.opclass = CLS_SYSTEM;
        dec_c.imm     = imm_i_c;
        writes_rd_c   = 1'b1;
      end
      default: begin
        // Includes any encoding with instr[1:0] != 2'b11.
        dec_c.opclass = CLS_ILLEGAL;
        dec_c.illegal = 1'b1;
      end
    endcase
    dec_c.reg_write = writes_rd_c & (dec_c.rd != '0);
  end

  // Pipeline register: flush kills, fire loads, consumption empties, stall holds.
  always_ff @(posedge clk) begin
    if (s_reset) begin
      out_valid_q <= 1'b0;
      dec_q       <= '0;
      held_rs1_q  <= '0;
      held_rs2_q  <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (fire_c) begin
      out_valid_q <= 1'b1;
      dec_q       <= dec_c;
      held_rs1_q  <= rs1_c;
      held_rs2_q  <= rs2_c;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_pc        = dec_q.pc;
  assign out_rd        = dec_q.rd;
  assign out_funct3    = dec_q.funct3;
  assign out_funct7_b5 = dec_q.funct7_b5;
  assign out_opclass   = dec_q.opclass;
  assign out_imm       = dec_q.imm;
  assign out_reg_write = dec_q.reg_write;
  assign out_illegal   = dec_q.illegal;

`ifdef DECODE_WB_BYPASS_EN
  logic                  hit1_q;
  logic                  hit2_q;
  logic [DATA_WIDTH-1:0] wb_data_q;

  // Remember a writeback that lands on the same edge as an rf read of that register.
  always_ff @(posedge clk) begin
    if (s_reset) begin
      hit1_q    <= 1'b0;
      hit2_q    <= 1'b0;
      wb_data_q <= '0;
    end else begin
      hit1_q    <= wb_we & (wb_address == rf_address1) & (rf_address1 != '0);
      hit2_q    <= wb_we & (wb_address == rf_address2) & (rf_address2 != '0);
      wb_data_q <= wb_data;
    end
  end

  assign out_rs1_data = hit1_q ? wb_data_q : rf_read_data_1;
  assign out_rs2_data = hit2_q ? wb_data_q : rf_read_data_2;
`else
  logic unused_wb_c;

  // Without bypass the writeback port is only observed by the rf itself.
  assign unused_wb_c  = ^{wb_we, wb_address, wb_data};
  assign out_rs1_data = rf_read_data_1;
  assign out_rs2_data = rf_read_data_2;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scoreboard bench for decode_stage with a small
// registered-read register file model.
module tb_decode_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          s_reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_instr;
  logic [DW-1:0] in_pc;
  logic [AW-1:0] rf_address1;
  logic [AW-1:0] rf_address2;
  logic [DW-1:0] rf_read_data_1;
  logic [DW-1:0] rf_read_data_2;
  logic          wb_we;
  logic [AW-1:0] wb_address;
  logic [DW-1:0] wb_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_pc;
  logic [AW-1:0] out_rd;
  logic [2:0]    out_funct3;
  logic          out_funct7_b5;
  logic [3:0]    out_opclass;
  logic [DW-1:0] out_imm;
  logic          out_reg_write;
  logic          out_illegal;
  logic [DW-1:0] out_rs1_data;
  logic [DW-1:0] out_rs2_data;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk            (clk),
    .s_reset        (s_reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .in_pc          (in_pc),
    .rf_address1    (rf_address1),
    .rf_address2    (rf_address2),
    .rf_read_data_1 (rf_read_data_1),
    .rf_read_data_2 (rf_read_data_2),
    .wb_we          (wb_we),
    .wb_address     (wb_address),
    .wb_data        (wb_data),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_rd         (out_rd),
    .out_funct3     (out_funct3),
    .out_funct7_b5  (out_funct7_b5),
    .out_opclass    (out_opclass),
    .out_imm        (out_imm),
    .out_reg_write  (out_reg_write),
    .out_illegal    (out_illegal),
    .out_rs1_data   (out_rs1_data),
    .out_rs2_data   (out_rs2_data)
  );

  // Register file model: registered reads, old value on same-edge read/write.
  logic [DW-1:0] regs [32];
  always @(posedge clk) begin
    if (s_reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? 32'h0 : 32'h100 + 32'(i);
      rf_read_data_1 <= '0;
      rf_read_data_2 <= '0;
    end else begin
      rf_read_data_1 <= regs[rf_address1];
      rf_read_data_2 <= regs[rf_address2];
      if (wb_we && wb_address != '0) regs[wb_address] <= wb_data;
    end
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        f7;
    logic [3:0]  opc;
    logic [31:0] imm;
    logic        rw;
    logic        ill;
  } exp_t;

  exp_t q[$];
  exp_t pend;
  logic m_valid;
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rd, input logic [2:0] f3,
                              input logic f7, input logic [3:0] opc, input logic [31:0] imm,
                              input logic rw, input logic ill);
    exp_t e;
    e.pc = pc; e.rd = rd; e.f3 = f3; e.f7 = f7; e.opc = opc; e.imm = imm; e.rw = rw; e.ill = ill;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic ordy, input logic fl, input exp_t e);
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    pend      = e;
    #1;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    wb_we = we; wb_address = a; wb_data = d;
  endtask

  // One clock: check in_ready, advance the scoreboard model, check registered outputs.
  task automatic step();
    logic rdy;
    logic fire;
    rdy  = !flush && (!m_valid || out_ready);
    fire = in_valid && rdy;
    if (!s_reset) chk("in_ready", 32'(in_ready), 32'(rdy));
    @(posedge clk);
    if (s_reset) begin
      q.delete();
      m_valid = 1'b0;
    end else if (flush) begin
      if (m_valid) void'(q.pop_front());
      m_valid = 1'b0;
    end else if (fire) begin
      if (m_valid) void'(q.pop_front());
      q.push_back(pend);
      m_valid = 1'b1;
    end else if (out_ready && m_valid) begin
      void'(q.pop_front());
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_pc",        out_pc,                 q[0].pc);
      chk("out_rd",        32'(out_rd),            32'(q[0].rd));
      chk("out_funct3",    32'(out_funct3),        32'(q[0].f3));
      chk("out_funct7_b5", 32'(out_funct7_b5),     32'(q[0].f7));
      chk("out_opclass",   32'(out_opclass),       32'(q[0].opc));
      chk("out_imm",       out_imm,                q[0].imm);
      chk("out_reg_write", 32'(out_reg_write),     32'(q[0].rw));
      chk("out_illegal",   32'(out_illegal),       32'(q[0].ill));
    end
  endtask

  localparam logic [31:0] I_ADDI = 32'hFFD08293;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LUI  = 32'h123452B7;
  localparam logic [31:0] I_SW   = 32'h0020A423;
  localparam logic [31:0] I_BEQ  = 32'hFE000EE3;
  localparam logic [31:0] I_JAL  = 32'h0080006F;
  localparam logic [31:0] I_LW   = 32'hFF812303;
  localparam logic [31:0] I_BAD  = 32'h0000007F;
  localparam logic [31:0] I_LOW  = 32'h00000011;

  initial begin
    exp_t none;
    exp_t e_add;
    none    = '0;
    m_valid = 1'b0;
    set_wb(1'b0, 5'd0, 32'h0);

    // Reset held with a valid instruction presented.
    s_reset = 1'b1;
    drive(1'b1, I_ADDI, 32'h100, 1'b1, 1'b0, none);
    step();
    step();
    chk("reset_out_imm", out_imm, 32'h0);
    chk("reset_out_rd", 32'(out_rd), 32'h0);
    s_reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, none);
    chk("reset_rf_address1", 32'(rf_address1), 32'h0);
    chk("reset_rf_address2", 32'(rf_address2), 32'h0);
    step();

    // addi x5,x1,-3
    drive(1'b1, I_ADDI, 32'h100, 1'b1, 1'b0, mk(32'h100, 5'd5, 3'd0, 1'b1, 4'd7, 32'hFFFFFFFD, 1'b1, 1'b0));
    chk("addi_rf_address1", 32'(rf_address1), 32'd1);
    chk("addi_rf_address2", 32'(rf_address2), 32'd29);
    step();
    chk("addi_rs1_data", out_rs1_data, 32'h101);
    chk("addi_rs2_data", out_rs2_data, 32'h11D);

    // add x3,x1,x2 then a three-cycle stall with a writeback to x1
    e_add = mk(32'h104, 5'd3, 3'd0, 1'b0, 4'd8, 32'h0, 1'b1, 1'b0);
    drive(1'b1, I_ADD, 32'h104, 1'b1, 1'b0, e_add);
    step();
    chk("add_rs1_data", out_rs1_data, 32'h101);
    chk("add_rs2_data", out_rs2_data, 32'h102);
    set_wb(1'b1, 5'd1, 32'hAAAA0001);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, none);
    chk("stall1_rf_address1", 32'(rf_address1), 32'd1);
    chk("stall1_rf_address2", 32'(rf_address2), 32'd2);
    step();
    chk("stall1_rs1_data", out_rs1_data, BYP ? 32'hAAAA0001 : 32'h101);
    set_wb(1'b0, 5'd0, 32'h0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, none);
    chk("stall2_rf_address1", 32'(rf_address1), 32'd1);
    step();
    chk("stall2_rs1_data", out_rs1_data, 32'hAAAA0001);
    chk("stall2_rs2_data", out_rs2_data, 32'h102);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, none);
    chk("stall3_rf_address2", 32'(rf_address2), 32'd2);
    step();
    chk("stall3_rs1_data", out_rs1_data, 32'hAAAA0001);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, none);
    step();

    // Same-edge writeback collision on x1 while add fires
    set_wb(1'b1, 5'd1, 32'h00001234);
    drive(1'b1, I_ADD, 32'h108, 1'b1, 1'b0, mk(32'h108, 5'd3, 3'd0, 1'b0, 4'd8, 32'h0, 1'b1, 1'b0));
    step();
    chk("byp_rs1_data", out_rs1_data, BYP ? 32'h00001234 : 32'hAAAA0001);
    chk("byp_rs2_data", out_rs2_data, 32'h102);
    set_wb(1'b1, 5'd0, 32'h00005555);
    drive(1'b1, I_ADD, 32'h10C, 1'b1, 1'b0, mk(32'h10C, 5'd3, 3'd0, 1'b0, 4'd8, 32'h0, 1'b1, 1'b0));
    step();
    chk("nobyp_rs1_data", out_rs1_data, 32'h00001234);
    drive(1'b1, I_BEQ, 32'h110, 1'b1, 1'b0, mk(32'h110, 5'd29, 3'd0, 1'b1, 4'd4, 32'hFFFFFFFC, 1'b0, 1'b0));
    step();
    chk("x0_rs1_data", out_rs1_data, 32'h0);
    chk("x0_rs2_data", out_rs2_data, 32'h0);
    set_wb(1'b0, 5'd0, 32'h0);

    // Flush while valid with a new instruction offered: not accepted
    drive(1'b1, I_LUI, 32'h114, 1'b1, 1'b1, none);
    chk("flush_in_ready", 32'(in_ready), 32'h0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, none);
    step();

    // Flush during a stall discards the held store; held indices survive
    drive(1'b1, I_SW, 32'h118, 1'b1, 1'b0, mk(32'h118, 5'd8, 3'd2, 1'b0, 4'd6, 32'h8, 1'b0, 1'b0));
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, none);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, none);
    chk("postflush_rf_address1", 32'(rf_address1), 32'd1);
    chk("postflush_rf_address2", 32'(rf_address2), 32'd2);
    step();

    // Back-to-back stream of assorted classes
    drive(1'b1, I_LUI, 32'h200, 1'b1, 1'b0, mk(32'h200, 5'd5, 3'd5, 1'b0, 4'd0, 32'h12345000, 1'b1, 1'b0));
    step();
    drive(1'b1, I_JAL, 32'h204, 1'b1, 1'b0, mk(32'h204, 5'd0, 3'd0, 1'b0, 4'd2, 32'h8, 1'b0, 1'b0));
    step();
    drive(1'b1, I_LW, 32'h208, 1'b1, 1'b0, mk(32'h208, 5'd6, 3'd2, 1'b1, 4'd5, 32'hFFFFFFF8, 1'b1, 1'b0));
    step();
    drive(1'b1, I_BAD, 32'h20C, 1'b1, 1'b0, mk(32'h20C, 5'd0, 3'd0, 1'b0, 4'd15, 32'h0, 1'b0, 1'b1));
    step();
    drive(1'b1, I_LOW, 32'h210, 1'b1, 1'b0, mk(32'h210, 5'd0, 3'd0, 1'b0, 4'd15, 32'h0, 1'b0, 1'b1));
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, none);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I instruction decode stage. Sits between fetch and execute, directly upstream of the register file (rf).
- Drives the rf read addresses and captures the decoded control fields into a pipeline register.
- Presents the rf read data (optionally bypassed from writeback) alongside the decoded instruction to execute.
- Valid/ready handshake on both sides, plus a flush input.

Parameters:
- DATA_WIDTH, 32, instruction/PC/operand width (RV32 only; other values unsupported).
- REGISTER_ADDRESS_WIDTH, 5, register index width; must match rf.

Ports:
- clk  input  1  clock
- s_reset  input  1  synchronous active-high reset
- in_valid  input  1  fetch has an instruction
- in_ready  output  1  decode accepts this cycle
- in_instr  input  DATA_WIDTH  raw instruction
- in_pc  input  DATA_WIDTH  instruction PC
- rf_address1  output  REGISTER_ADDRESS_WIDTH  to rf address1 (rs1)
- rf_address2  output  REGISTER_ADDRESS_WIDTH  to rf address2 (rs2)
- rf_read_data_1  input  DATA_WIDTH  from rf read_data_1
- rf_read_data_2  input  DATA_WIDTH  from rf read_data_2
- wb_we  input  1  writeback write enable (same signal as rf we)
- wb_address  input  REGISTER_ADDRESS_WIDTH  writeback rd (rf address3)
- wb_data  input  DATA_WIDTH  writeback data (rf write_data)
- flush  input  1  kill the instruction in decode (taken branch/jump)
- out_valid  output  1  decoded instruction valid
- out_ready  input  1  execute accepts
- out_pc  output  DATA_WIDTH  PC of decoded instruction
- out_rd  output  REGISTER_ADDRESS_WIDTH  destination register
- out_funct3  output  3  instr[14:12]
- out_funct7_b5  output  1  instr[30]
- out_opclass  output  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP_IMM, 8 OP, 9 MISC_MEM, 10 SYSTEM, 15 ILLEGAL
- out_imm  output  DATA_WIDTH  sign-extended immediate (I/S/B/U/J per class; 0 for OP and ILLEGAL)
- out_reg_write  output  1  class writes rd and rd != 0
- out_illegal  output  1  opcode not in RV32I set, or instr[1:0] != 2'b11
- out_rs1_data  output  DATA_WIDTH  rs1 operand
- out_rs2_data  output  DATA_WIDTH  rs2 operand

Behaviour:
- All state updates on posedge clk. s_reset has priority over everything.
- Reset values:
  - out_valid = 0; all out_* fields = 0.
  - Held rs1/rs2 indices = 0, so rf_address1/2 = 0.
  - Bypass state cleared.
- Handshake:
  - in_ready = ~flush & (~out_valid | out_ready).
  - fire = in_valid & in_ready.
- On fire:
  - Decoded fields, in_pc and instr[19:15]/[24:20] are registered.
  - out_valid <= 1 on the next edge. Latency is 1 cycle.
- No fire and out_ready = 1: out_valid <= 0.
- out_valid = 1 and out_ready = 0 (stall): all out_* hold stable.
- Address mux, combinational:
  - rf_address1 = fire ? in_instr[19:15] : held_rs1; same for rf_address2 with [24:20].
  - Required because rf reads are registered and re-read every cycle: operand data is valid in the same cycle as out_valid, and stays correct throughout a stall.
- Flush:
  - out_valid <= 0 on the next edge; in_ready = 0 in the flush cycle.
  - Held indices are unchanged.
  - flush during a stall discards the held instruction.
- Operands without the optional feature: out_rs1_data = rf_read_data_1 and out_rs2_data = rf_read_data_2, straight through.
- Immediates:
  - I = instr[31:20]; S = {[31:25],[11:7]}; B = {[31],[7],[30:25],[11:8],0}; J = {[31],[19:12],[20],[30:21],0}.
  - I, S, B and J are sign-extended from instr[31].
  - U = {[31:12], 12'b0}.
- rd == 0 forces out_reg_write = 0.
- out_illegal = 1 forces out_reg_write = 0 and out_opclass = 15.
- The instruction is still passed with out_valid = 1 so execute can trap.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Purpose: rf returns the old value when a read and a write to the same register occur on the same edge.
- When defined:
  - Each cycle, register hitN = wb_we & (wb_address == rf_addressN) & (rf_addressN != 0), plus wb_data.
  - Next cycle: out_rsN_data = hitN ? captured wb_data : rf_read_data_N.
  - Applies in fire and stall cycles alike.
- When undefined: no bypass logic. Software/hazard unit must avoid the same-edge write/read collision.

Test Plan:
- s_reset = 1 for 2 cycles with in_valid = 1 -> out_valid = 0, rf_address1/2 = 0, out_imm = 0; in_ready = 1 after reset drops.
- in_instr = 0xFFD08293 (addi x5,x1,-3), out_ready = 1 -> rf_address1 = 1 in the fire cycle; next cycle out_valid = 1, out_rd = 5, out_opclass = 7, out_imm = 0xFFFFFFFD, out_reg_write = 1.
- 0x002081B3 (add x3,x1,x2) accepted, then out_ready = 0 for 3 cycles -> in_ready = 0, rf_address1/2 held at 1/2, out_* stable, out_rs1_data tracks the rf; released -> out_valid = 0 next cycle if in_valid = 0.
- DECODE_WB_BYPASS_EN defined: add x3,x1,x2 fires while wb_we = 1, wb_address = 1, wb_data = 0x00001234, rf holds x1 = 0 -> out_rs1_data = 0x00001234; repeat with wb_address = 0 -> no bypass, out_rs1_data = rf value.
- out_valid = 1, flush = 1 with in_valid = 1 -> in_ready = 0 that cycle, out_valid = 0 next cycle, incoming instruction not accepted.
- in_instr = 0x0000007F -> out_illegal = 1, out_opclass = 15, out_reg_write = 0, out_valid = 1.
